// File: rtl/bus_dev_port.sv
// ---------------------------------------------------------------------------
// bus_dev_port
//   Device-side endpoint of the shared bus. It sits between a device's host
//   logic and one bus slot.
//   TX path: the host writes packets into a first-word-fall-through FIFO,
//   and the bus drains that FIFO through pndng/D_pop/pop.
//   RX path: the bus delivers packets through push/D_push. Packets addressed
//   to DEV_ID or BCAST are queued for the host, which reads them over a
//   valid/ready interface. All other packets are counted as misroutes and
//   dropped.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   tx_data      : host packet to send
//   tx_valid     : host offers tx_data
//   tx_ready     : TX FIFO not full
//   pndng        : TX FIFO not empty (to bus)
//   D_pop        : TX FIFO head (to bus), masked to 0 while empty
//   pop          : bus consumes the TX head
//   push         : bus delivers D_push
//   D_push       : packet from bus
//   rx_data      : RX FIFO head, masked to 0 while empty
//   rx_valid     : RX FIFO not empty
//   rx_ready     : host consumes the RX head
//   tx_count     : TX occupancy
//   rx_count     : RX occupancy
//   rx_overflow  : sticky, an accepted-ID packet was dropped because RX was full
//   misroute_cnt : saturating count of pushes for other devices
// ---------------------------------------------------------------------------
module bus_dev_port #(
    parameter int unsigned PCKG_SZ = 16,
    parameter int unsigned DEPTH   = 8,
    parameter logic [7:0]  DEV_ID  = 8'h00,
    parameter logic [7:0]  BCAST   = 8'hFF,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PCKG_SZ-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               pndng,
    output logic [PCKG_SZ-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [PCKG_SZ-1:0] D_push,
    output logic [PCKG_SZ-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [CW-1:0]      tx_count,
    output logic [CW-1:0]      rx_count,
    output logic               rx_overflow,
    output logic [7:0]         misroute_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // ---------------- TX FIFO ----------------
    logic [PCKG_SZ-1:0] tx_mem_q [DEPTH];
    logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0]      tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0]      tx_count_q, tx_count_d;
    logic               tx_wr, tx_rd;

    // ---------------- RX FIFO ----------------
    logic [PCKG_SZ-1:0] rx_mem_q [DEPTH];
    logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0]      rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0]      rx_count_q, rx_count_d;
    logic               rx_wr, rx_rd;
    logic               rx_overflow_q, rx_overflow_d;
    logic [7:0]         misroute_q, misroute_d;

    logic [7:0]         dst;
    logic               dst_ok;

    // Status flags are decoded only from the registered counts. None of
    // them depends combinationally on pop, push or rx_ready.
    assign tx_ready = (tx_count_q != FULL_CNT);
    assign pndng    = (tx_count_q != '0);
    assign rx_valid = (rx_count_q != '0);

    // Storage is not cleared on reset, so the heads are masked while the
    // FIFO is empty. Because the counts reset asynchronously, the masking
    // also takes effect asynchronously.
    assign D_pop   = pndng    ? tx_mem_q[tx_rd_ptr_q] : '0;
    assign rx_data = rx_valid ? rx_mem_q[rx_rd_ptr_q] : '0;

    assign tx_count     = tx_count_q;
    assign rx_count     = rx_count_q;
    assign rx_overflow  = rx_overflow_q;
    assign misroute_cnt = misroute_q;

    assign dst    = D_push[PCKG_SZ-1 -: 8];
    assign dst_ok = (dst == DEV_ID) || (dst == BCAST);

    assign tx_wr = tx_valid && tx_ready;
    assign tx_rd = pop && pndng;
    assign rx_rd = rx_valid && rx_ready;
    // When RX is full, a host read in the same cycle frees the slot that
    // the incoming packet lands in.
    assign rx_wr = push && dst_ok && ((rx_count_q != FULL_CNT) || rx_rd);

    always_comb begin
        tx_wr_ptr_d   = tx_wr_ptr_q;
        tx_rd_ptr_d   = tx_rd_ptr_q;
        tx_count_d    = tx_count_q;
        rx_wr_ptr_d   = rx_wr_ptr_q;
        rx_rd_ptr_d   = rx_rd_ptr_q;
        rx_count_d    = rx_count_q;
        rx_overflow_d = rx_overflow_q;
        misroute_d    = misroute_q;

        if (tx_wr) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
        if (tx_rd) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
        if (tx_wr && !tx_rd) tx_count_d = tx_count_q + CW'(1);
        else if (!tx_wr && tx_rd) tx_count_d = tx_count_q - CW'(1);

        if (rx_wr) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
        if (rx_rd) rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
        if (rx_wr && !rx_rd) rx_count_d = rx_count_q + CW'(1);
        else if (!rx_wr && rx_rd) rx_count_d = rx_count_q - CW'(1);

        if (push && dst_ok && !rx_wr) rx_overflow_d = 1'b1;
        if (push && !dst_ok && (misroute_q != 8'hFF)) misroute_d = misroute_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            rx_overflow_q <= 1'b0;
            misroute_q    <= '0;
        end else begin
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            rx_overflow_q <= rx_overflow_d;
            misroute_q    <= misroute_d;
        end
    end

    // The storage arrays have no reset. Emptiness is tracked by the counts.
    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem_q[tx_wr_ptr_q] <= tx_data;
        if (rx_wr) rx_mem_q[rx_wr_ptr_q] <= D_push;
    end

endmodule

// File: tb/tb_bus_dev_port.sv
module tb_bus_dev_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [15:0] D_push = '0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [3:0]  tx_count;
    logic [3:0]  rx_count;
    logic        rx_overflow;
    logic [7:0]  misroute_cnt;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    int unsigned tx_m = 0;
    int unsigned rx_m = 0;
    int unsigned mis_m = 0;
    logic        ovf_m = 1'b0;

    bus_dev_port #(.PCKG_SZ(16), .DEPTH(8), .DEV_ID(8'h02), .BCAST(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count),
        .rx_overflow(rx_overflow), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on the falling edge, a handshake that is about to complete at
    // the next rising edge pops the scoreboard and checks the presented data.
    always @(negedge clk) begin
        if (reset) begin
            if (pop && pndng) begin
                if (tx_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL D_pop_unexpected: got %h expected none", D_pop);
                end else check("D_pop", D_pop, tx_q.pop_front());
            end
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rx_data_unexpected: got %h expected none", rx_data);
                end else check("rx_data", rx_data, rx_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of stimulus, records the expected responses, and
    // advances past the rising edge.
    task automatic cycle(input logic tv, input logic [15:0] td, input logic pp,
                         input logic ps, input logic [15:0] dp, input logic rr);
        logic tw, tr, acc, rw, rd;
        tx_valid = tv; tx_data = td; pop = pp;
        push = ps; D_push = dp; rx_ready = rr;
        tw  = tv && (tx_m != 8);
        tr  = pp && (tx_m != 0);
        if (tw) tx_q.push_back(td);
        tx_m = tx_m + (tw ? 1 : 0) - (tr ? 1 : 0);
        rd  = rr && (rx_m != 0);
        acc = ps && (dp[15:8] == 8'h02 || dp[15:8] == 8'hFF);
        if (ps && !acc && mis_m != 255) mis_m++;
        rw  = acc && ((rx_m != 8) || rd);
        if (acc && !rw) ovf_m = 1'b1;
        if (rw) rx_q.push_back(dp);
        rx_m = rx_m + (rw ? 1 : 0) - (rd ? 1 : 0);
        step();
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".tx_count"}, tx_count, tx_m);
        check({tag, ".rx_count"}, rx_count, rx_m);
        check({tag, ".pndng"}, pndng, tx_m != 0);
        check({tag, ".tx_ready"}, tx_ready, tx_m != 8);
        check({tag, ".rx_valid"}, rx_valid, rx_m != 0);
        check({tag, ".rx_overflow"}, rx_overflow, ovf_m);
        check({tag, ".misroute"}, misroute_cnt, mis_m);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pndng"}, pndng, 0);
        check({tag, ".tx_ready"}, tx_ready, 1);
        check({tag, ".rx_valid"}, rx_valid, 0);
        check({tag, ".D_pop"}, D_pop, 16'h0);
        check({tag, ".rx_data"}, rx_data, 16'h0);
        check({tag, ".tx_count"}, tx_count, 0);
        check({tag, ".rx_count"}, rx_count, 0);
        check({tag, ".rx_overflow"}, rx_overflow, 0);
        check({tag, ".misroute"}, misroute_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and first send
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        check_reset_outputs("rst");
        cycle(1'b1, 16'h0103, 1'b0, 1'b0, 16'h0, 1'b0);
        check("first.pndng", pndng, 1);
        check("first.D_pop", D_pop, 16'h0103);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("first.pndng_after_pop", pndng, 0);
        check("first.tx_count", tx_count, 0);
        idle();

        // TX full/drain: the ninth packet must be refused
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
            check("full.tx_ready", tx_ready, (i < 7) ? 1 : 0);
        end
        idle();
        check("full.tx_count", tx_count, 8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("drain.pndng", pndng, 0);
        idle();
        check_state("drain");

        // RX filter with DEV_ID 8'h02
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0211, 1'b0);
        check("filt.rx_data", rx_data, 16'h0211);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'hFF22, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0533, 1'b0);
        check("filt.misroute", misroute_cnt, 1);
        check("filt.rx_count", rx_count, 2);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        check("filt.rx_valid", rx_valid, 0);
        idle();

        // RX overflow, then a push while full that coincides with a read
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0240 + 16'(i), 1'b0);
        check("ovf.rx_count_full", rx_count, 8);
        check("ovf.sticky_before", rx_overflow, 0);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h0299, 1'b0);
        check("ovf.rx_overflow", rx_overflow, 1);
        check("ovf.rx_count_drop", rx_count, 8);
        cycle(1'b0, 16'h0, 1'b0, 1'b1, 16'h02AA, 1'b1);
        check("ovf.rx_count_simul", rx_count, 8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        idle();
        check_state("ovf");

        // Wrap-around with concurrent traffic on both FIFOs
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b1, 16'h0230 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'h0310 + 16'(i), 1'b1, 1'b1, 16'hFF40 + 16'(i), 1'b1);
            check("wrap.tx_count", tx_count, 3);
            check("wrap.rx_count", rx_count, 3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
        idle();
        check_state("wrap");

        // Asynchronous reset between edges with 5 entries in each FIFO
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 16'h0400 + 16'(i), 1'b0, 1'b1, 16'h0250 + 16'(i), 1'b0);
        idle();
        check("pre_rst.tx_count", tx_count, 5);
        check("pre_rst.rx_count", rx_count, 5);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tx_q.delete(); rx_q.delete();
        tx_m = 0; rx_m = 0; mis_m = 0; ovf_m = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        check_state("post_rst");
        cycle(1'b1, 16'h0777, 1'b0, 1'b1, 16'hFF77, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
        idle();
        check_state("final");

        check("tx_scoreboard_empty", tx_q.size(), 0);
        check("rx_scoreboard_empty", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
